// File: rtl/literal_collector.sv
// Collects 5-bit literal groups (continuation flag + nibble) into a left-aligned 64-bit number.
// Optional feature: LITERAL_COLLECTOR_OVERFLOW_DETECT_EN ends a literal on its 17th group and flags overflow.
module literal_collector (
  input  logic        clk,
  input  logic        resetB,
  input  logic        start,
  input  logic        groupValid,
  input  logic [4:0]  group,
  output logic        groupReady,
  output logic        done,
  output logic [16:0] validNibbles,
  output logic [63:0] packedNumber,
  output logic [4:0]  groupCount,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state_q;
  logic [63:0] packed_q, packed_d;
  logic [16:0] vn_q, vn_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ready_q, done_q, busy_q;
  logic        accept_s, last_s;

  // ready_q is high only in COLLECT, so it alone qualifies an accept
  assign accept_s = groupValid & ready_q;

  // Datapath next-state for one accepted group; groups past the 16th leave the number untouched
  always_comb begin
    packed_d = packed_q;
    vn_d     = vn_q;
    cnt_d    = cnt_q;
    last_s   = 1'b0;
    if (accept_s) begin
      for (int i = 0; i < 16; i++) begin
        packed_d[63-4*i -: 4] = (cnt_q == 5'(i)) ? group[3:0] : packed_q[63-4*i -: 4];
        vn_d[i]               = vn_q[i] | (cnt_q == 5'(i));
      end
      cnt_d = (cnt_q == 5'd17) ? 5'd17 : cnt_q + 5'd1;
`ifdef LITERAL_COLLECTOR_OVERFLOW_DETECT_EN
      if (cnt_q == 5'd16) begin
        vn_d[16] = 1'b1;
        last_s   = 1'b1;
      end else begin
        last_s   = ~group[4];
      end
`else
      last_s = ~group[4];
`endif
    end else begin
      last_s = 1'b0;
    end
  end

  // Control FSM; all outputs are registered decodes of the state being entered
  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state_q  <= IDLE;
      packed_q <= 64'd0;
      vn_q     <= 17'd0;
      cnt_q    <= 5'd0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= COLLECT;
            packed_q <= 64'd0;
            vn_q     <= 17'd0;
            cnt_q    <= 5'd0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
          end
        end
        COLLECT: begin
          packed_q <= packed_d;
          vn_q     <= vn_d;
          cnt_q    <= cnt_d;
          if (last_s) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
            ready_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign groupReady   = ready_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign packedNumber = packed_q;
  assign validNibbles = vn_q;
  assign groupCount   = cnt_q;

endmodule

// File: tb/tb_literal_collector.sv
// Self-checking bench for literal_collector: scenario tasks with a scoreboard of expected literals.
module tb_literal_collector;

  logic        clk = 1'b0;
  logic        resetB, start, groupValid;
  logic [4:0]  group;
  logic        groupReady, done, busy;
  logic [16:0] validNibbles;
  logic [63:0] packedNumber;
  logic [4:0]  groupCount;

  typedef struct {
    logic [63:0] pk;
    logic [16:0] vn;
    logic [4:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done   = 0;

  always #5 clk = ~clk;

  literal_collector dut (
    .clk(clk), .resetB(resetB), .start(start), .groupValid(groupValid), .group(group),
    .groupReady(groupReady), .done(done), .validNibbles(validNibbles),
    .packedNumber(packedNumber), .groupCount(groupCount), .busy(busy)
  );

  // counts every cycle in which done was high
  always @(posedge clk) if (done === 1'b1) n_done++;

  // Reference: literal content implied by a list of groups
  function automatic exp_t model(input logic [4:0] gs[$]);
    exp_t e;
    e.pk = 64'd0; e.vn = 17'd0; e.cnt = 5'd0;
    for (int k = 0; k < gs.size(); k++) begin
      if (k < 16) begin
        e.pk[63-4*k -: 4] = gs[k][3:0];
        e.vn[k] = 1'b1;
      end
      if (e.cnt < 5'd17) e.cnt = e.cnt + 5'd1;
`ifdef LITERAL_COLLECTOR_OVERFLOW_DETECT_EN
      if (k == 16) begin
        e.vn[16] = 1'b1;
        break;
      end
`endif
      if (!gs[k][4]) break;
    end
    return e;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic drive(input logic [4:0] g);
    groupValid = 1'b1; group = g;
    @(negedge clk);
    groupValid = 1'b0; group = 5'd0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({packedNumber, validNibbles, groupCount, groupReady, done, busy} !== 90'd0) begin
      n_fail++;
      $display("FAIL reset_state: got pk=%h vn=%h cnt=%0d rdy=%b done=%b busy=%b want all 0",
               packedNumber, validNibbles, groupCount, groupReady, done, busy);
    end
    @(negedge clk); resetB = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || groupReady !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b want 0 0", busy, groupReady);
    end
  endtask

  task automatic test_single_group();
    exp_t e; bit ok; int d0;
    sb.push_back('{64'hA000_0000_0000_0000, 17'h00001, 5'd1});
    do_start();
    d0 = n_done;
    drive(5'b01010);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done); end
    wait_idle(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || packedNumber !== e.pk || validNibbles !== e.vn || groupCount !== e.cnt || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL single_result: got ok=%b pk=%h vn=%h cnt=%0d pulses=%0d want pk=%h vn=%h cnt=%0d pulses=1",
               ok, packedNumber, validNibbles, groupCount, n_done - d0, e.pk, e.vn, e.cnt);
    end
    // groups presented while idle must be ignored
    groupValid = 1'b1; group = 5'b00011;
    repeat (3) @(negedge clk);
    groupValid = 1'b0;
    n_checks++;
    if (packedNumber !== e.pk || validNibbles !== e.vn || groupCount !== e.cnt || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid_ignored: got pk=%h vn=%h cnt=%0d busy=%b want pk=%h vn=%h cnt=%0d busy=0",
               packedNumber, validNibbles, groupCount, busy, e.pk, e.vn, e.cnt);
    end
  endtask

  task automatic test_literal_2021();
    logic [4:0] gs[$]; exp_t e; bit ok; int d0;
    gs = '{5'b10111, 5'b11110, 5'b00101};
    sb.push_back('{64'h7E50_0000_0000_0000, 17'h00007, 5'd3});
    do_start();
    n_checks++;
    if (packedNumber !== 64'd0 || validNibbles !== 17'd0 || groupCount !== 5'd0 || groupReady !== 1'b1) begin
      n_fail++;
      $display("FAIL start_clear: got pk=%h vn=%h cnt=%0d rdy=%b want 0 0 0 1",
               packedNumber, validNibbles, groupCount, groupReady);
    end
    d0 = n_done;
    foreach (gs[i]) drive(gs[i]);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL l2021_done_timing: got done=%b busy=%b want 1 1", done, busy);
    end
    wait_idle(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || packedNumber !== e.pk || validNibbles !== e.vn || groupCount !== e.cnt || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL l2021_result: got ok=%b pk=%h vn=%h cnt=%0d pulses=%0d want pk=%h vn=%h cnt=%0d pulses=1",
               ok, packedNumber, validNibbles, groupCount, n_done - d0, e.pk, e.vn, e.cnt);
    end
  endtask

  task automatic test_back_pressure();
    logic [4:0] gs[$]; exp_t e; bit ok; int d0; int gi;
    logic [5:0] pat;
    pat = 6'b101001;
    gs  = '{5'b10011, 5'b11100, 5'b00110};
    sb.push_back(model(gs));
    do_start();
    d0 = n_done; gi = 0;
    for (int c = 0; c < 6; c++) begin
      if (pat[c]) begin
        drive(gs[gi]); gi++;
      end else begin
        groupValid = 1'b0; group = 5'b01111; start = (c == 2);
        @(negedge clk);
        start = 1'b0; group = 5'd0;
      end
      if (c == 2) begin
        n_checks++;
        if (groupCount !== 5'd1 || packedNumber !== 64'h3000_0000_0000_0000 || validNibbles !== 17'h1 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_hold_and_start: got cnt=%0d pk=%h vn=%h busy=%b want 1 3000000000000000 1 1",
                   groupCount, packedNumber, validNibbles, busy);
        end
      end
    end
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", done); end
    wait_idle(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || packedNumber !== e.pk || validNibbles !== e.vn || groupCount !== e.cnt || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL bp_result: got ok=%b pk=%h vn=%h cnt=%0d pulses=%0d want pk=%h vn=%h cnt=%0d pulses=1",
               ok, packedNumber, validNibbles, groupCount, n_done - d0, e.pk, e.vn, e.cnt);
    end
  endtask

  task automatic test_long(input string name, input logic [4:0] nib, input logic [4:0] g16,
                           input logic [4:0] g17, input bit use17);
    logic [4:0] gs[$]; exp_t e; bit ok; int d0;
    for (int i = 0; i < 16; i++) gs.push_back(nib);
    gs.push_back(g16);
    if (use17) gs.push_back(g17);
    sb.push_back(model(gs));
    do_start();
    d0 = n_done;
    foreach (gs[i]) drive(gs[i]);
    wait_idle(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || packedNumber !== e.pk || validNibbles !== e.vn || groupCount !== e.cnt || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL %s: got ok=%b pk=%h vn=%h cnt=%0d pulses=%0d want pk=%h vn=%h cnt=%0d pulses=1",
               name, ok, packedNumber, validNibbles, groupCount, n_done - d0, e.pk, e.vn, e.cnt);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    do_start();
    drive(5'b10001);
    drive(5'b10010);
    d0 = n_done;
    #3 resetB = 1'b0;
    #1;
    n_checks++;
    if ({packedNumber, validNibbles, groupCount, groupReady, done, busy} !== 90'd0) begin
      n_fail++;
      $display("FAIL async_reset: got pk=%h vn=%h cnt=%0d rdy=%b done=%b busy=%b want all 0",
               packedNumber, validNibbles, groupCount, groupReady, done, busy);
    end
    repeat (2) @(negedge clk);
    resetB = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_done: got pulses=%0d busy=%b want 0 0", n_done - d0, busy);
    end
  endtask

  task automatic test_after_reset();
    exp_t e; bit ok; int d0;
    sb.push_back('{64'h5000_0000_0000_0000, 17'h00001, 5'd1});
    do_start();
    d0 = n_done;
    drive(5'b00101);
    wait_idle(ok);
    e = sb.pop_front();
    n_checks++;
    if (!ok || packedNumber !== e.pk || validNibbles !== e.vn || groupCount !== e.cnt || n_done - d0 != 1) begin
      n_fail++;
      $display("FAIL after_reset: got ok=%b pk=%h vn=%h cnt=%0d pulses=%0d want pk=%h vn=%h cnt=%0d pulses=1",
               ok, packedNumber, validNibbles, groupCount, n_done - d0, e.pk, e.vn, e.cnt);
    end
  endtask

  initial begin
    resetB = 1'b0; start = 1'b0; groupValid = 1'b0; group = 5'd0;
    test_reset();
    test_single_group();
    test_literal_2021();
    test_back_pressure();
    test_long("sixteen_ones", 5'b11111, 5'b00001, 5'b00000, 1'b0);
    test_long("saturation", 5'b11010, 5'b11100, 5'b00111, 1'b1);
    test_async_reset();
    test_after_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
